// File: rtl/key_loader_pkg.sv
// Shared constants and state encoding for the serial key loader.
// Counter widths are derived here so the FSM follows any change of frame or timeout size.
package key_loader_pkg;

    localparam int KEY_W       = 7;
    localparam int FRAME_W     = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAX_FAIL    = 3;

    localparam int CNT_W  = $clog2(FRAME_W);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_ARMED   = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

endpackage

// File: rtl/key_loader.sv
// Serial key loader: shifts an LSB-first key frame with even parity and drives the
// locked netlist's key bus only once the frame has been verified.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no frame since reset, key bus zero
// SHIFT   | collecting frame bits, idle-cycle timeout running
// CHECK   | full frame held, parity evaluated this cycle
// ARMED   | verified key driven on keyinput
// ERROR   | parity error or timeout, waiting for a new load_start
// LOCKOUT | too many consecutive failures, only rst leaves
module key_loader
    import key_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit_valid,
    input  logic             key_sdi,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_armed,
    output logic             key_error,
    output logic             busy,
    output logic             locked_out
);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [FAIL_W-1:0] FAIL_SAT = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_PRE = FAIL_W'(MAX_FAIL - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TMO_W-1:0]   tmo_q,   tmo_d;
    logic [FAIL_W-1:0]  fail_q,  fail_d;
    logic [KEY_W-1:0]   keyinput_q, keyinput_d;
    logic               key_armed_q, key_armed_d;
    logic               key_error_q, key_error_d;
    logic               busy_q, busy_d;
    logic               locked_out_q, locked_out_d;
    logic               start_frame;
    logic               fail_hit;

    // LOCKOUT ignores load_start; everywhere else it (re)opens a frame and wins over a bit.
    assign start_frame = load_start && (state_q != ST_LOCKOUT);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        fail_d   = fail_q;
        fail_hit = 1'b0;

        if (start_frame) begin
            state_d = ST_SHIFT;
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (key_bit_valid) begin
                        // New bits enter at the top so the first bit ends up in bit 0.
                        shift_d = {key_sdi, shift_q[FRAME_W-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                        tmo_d   = '0;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_CHECK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        fail_hit = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (^shift_q == 1'b0) begin
                        state_d = ST_ARMED;
                        fail_d  = '0;
                    end else begin
                        fail_hit = 1'b1;
                    end
                end
                ST_IDLE, ST_ARMED, ST_ERROR, ST_LOCKOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (fail_hit) begin
            fail_d  = (fail_q == FAIL_SAT) ? fail_q : fail_q + 1'b1;
            state_d = (fail_q >= FAIL_PRE) ? ST_LOCKOUT : ST_ERROR;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        keyinput_d   = (state_d == ST_ARMED) ? shift_d[KEY_W-1:0] : '0;
        key_armed_d  = (state_d == ST_ARMED);
        key_error_d  = (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
        busy_d       = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            fail_q       <= '0;
            keyinput_q   <= '0;
            key_armed_q  <= 1'b0;
            key_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            fail_q       <= fail_d;
            keyinput_q   <= keyinput_d;
            key_armed_q  <= key_armed_d;
            key_error_q  <= key_error_d;
            busy_q       <= busy_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign keyinput   = keyinput_q;
    assign key_armed  = key_armed_q;
    assign key_error  = key_error_q;
    assign busy       = busy_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good/bad frames, timeout, reload, reset and lockout.
module tb_key_loader;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       key_bit_valid;
    logic       key_sdi;
    logic [6:0] keyinput;
    logic       key_armed;
    logic       key_error;
    logic       busy;
    logic       locked_out;

    int total = 0;
    int bad   = 0;

    key_loader dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .key_bit_valid (key_bit_valid),
        .key_sdi       (key_sdi),
        .keyinput      (keyinput),
        .key_armed     (key_armed),
        .key_error     (key_error),
        .busy          (busy),
        .locked_out    (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and outputs both settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] key, input logic par);
        for (int i = 0; i < 7; i++) begin
            key_bit_valid = 1'b1;
            key_sdi       = key[i];
            tick();
        end
        key_bit_valid = 1'b1;
        key_sdi       = par;
        tick();
        key_bit_valid = 1'b0;
        key_sdi       = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [6:0] k, input logic a,
                           input logic e, input logic b, input logic l);
        chk({tag, ".keyinput"},   32'(keyinput),   32'(k));
        chk({tag, ".key_armed"},  32'(key_armed),  32'(a));
        chk({tag, ".key_error"},  32'(key_error),  32'(e));
        chk({tag, ".busy"},       32'(busy),       32'(b));
        chk({tag, ".locked_out"}, 32'(locked_out), 32'(l));
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; key_bit_valid = 1'b0; key_sdi = 1'b0;
        tick(); tick();
        chk_out("reset", 7'h00, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out("idle", 7'h00, 0, 0, 0, 0);

        // Bits presented in IDLE are ignored.
        key_bit_valid = 1'b1; key_sdi = 1'b1;
        tick();
        key_bit_valid = 1'b0; key_sdi = 1'b0;
        chk_out("idle_bit", 7'h00, 0, 0, 0, 0);

        // Good frame 1,0,1,0,1,1,0 + parity 0 -> 0x35
        start();
        chk_out("shift", 7'h00, 0, 0, 1, 0);
        send_frame(7'h35, 1'b0);
        chk_out("check", 7'h00, 0, 0, 1, 0);
        tick();
        chk_out("armed", 7'h35, 1, 0, 0, 0);
        tick();
        chk_out("armed_hold", 7'h35, 1, 0, 0, 0);

        // Reload from ARMED zeros the bus on the next cycle.
        start();
        chk_out("reload", 7'h00, 0, 0, 1, 0);
        send_frame(7'h35, 1'b0);
        tick();
        chk_out("rearm", 7'h35, 1, 0, 0, 0);

        // Reset in ARMED discards the key.
        rst = 1'b1;
        tick();
        chk_out("rst_armed", 7'h00, 0, 0, 0, 0);
        rst = 1'b0;

        // Bad parity -> ERROR
        start();
        send_frame(7'h35, 1'b1);
        tick();
        chk_out("parity_err", 7'h00, 0, 1, 0, 0);
        key_bit_valid = 1'b1; key_sdi = 1'b1;
        tick();
        key_bit_valid = 1'b0; key_sdi = 1'b0;
        chk_out("err_bit_ignored", 7'h00, 0, 1, 0, 0);

        // Start and bit in the same cycle: bit discarded, then good frame (also clears failures).
        load_start = 1'b1; key_bit_valid = 1'b1; key_sdi = 1'b1;
        tick();
        load_start = 1'b0; key_bit_valid = 1'b0; key_sdi = 1'b0;
        send_frame(7'h35, 1'b0);
        tick();
        chk_out("start_plus_bit", 7'h35, 1, 0, 0, 0);

        // Different key: 0x4A has three ones, parity 1.
        start();
        send_frame(7'h4A, 1'b1);
        tick();
        chk_out("key_4a", 7'h4A, 1, 0, 0, 0);

        // Timeout: 3 bits, then 16 idle cycles.
        start();
        for (int i = 0; i < 3; i++) begin
            key_bit_valid = 1'b1; key_sdi = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0; key_sdi = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk_out("tmo_15", 7'h00, 0, 0, 1, 0);
        tick();
        chk_out("tmo_16", 7'h00, 0, 1, 0, 0);

        // Lockout: fresh reset, three bad frames back to back.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            start();
            send_frame(7'h35, 1'b1);
            tick();
        end
        chk_out("two_bad", 7'h00, 0, 1, 0, 0);
        start();
        send_frame(7'h35, 1'b1);
        tick();
        chk_out("lockout", 7'h00, 0, 1, 0, 1);
        start();
        chk_out("lock_start_ignored", 7'h00, 0, 1, 0, 1);
        send_frame(7'h35, 1'b0);
        tick(); tick();
        chk_out("lock_good_ignored", 7'h00, 0, 1, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("lock_rst", 7'h00, 0, 0, 0, 0);

        // Timeout counts as failure too: two timeouts then bad parity -> LOCKOUT.
        for (int f = 0; f < 2; f++) begin
            start();
            for (int i = 0; i < 16; i++) tick();
        end
        chk_out("two_tmo", 7'h00, 0, 1, 0, 0);
        start();
        send_frame(7'h00, 1'b1);
        tick();
        chk_out("tmo_lockout", 7'h00, 0, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load_start  input  1  single-cycle pulse that opens a key frame.
REQ-005 key_bit_valid  input  1  qualifies key_sdi for one cycle.
REQ-006 key_sdi  input  1  serial key data, LSB first.
REQ-007 keyinput  output  7  key bus to the locked netlist; bit n drives keyinput<n>.
REQ-008 key_armed  output  1  high while keyinput carries a verified key.
REQ-009 key_error  output  1  high in ERROR and LOCKOUT.
REQ-010 busy  output  1  high in SHIFT and CHECK.
REQ-011 locked_out  output  1  high in LOCKOUT.

Function
REQ-012 A frame SHALL be 8 bits: key bits 0..6 in order, then 1 even-parity bit (total ones, parity included, even).
REQ-013 The FSM SHALL have states IDLE, SHIFT, CHECK, ARMED, ERROR and LOCKOUT.
- IDLE -> SHIFT on load_start.
- SHIFT -> CHECK on acceptance of the 8th bit.
- CHECK -> ARMED if parity is good.
- CHECK -> ERROR if parity is bad.
REQ-014 In SHIFT, each cycle with key_bit_valid high SHALL shift one bit and increment a 3-bit bit counter.
REQ-015 Bits presented outside SHIFT SHALL be ignored.
REQ-016 If load_start and key_bit_valid are high in the same cycle, the block SHALL treat it as a start and discard the bit.
REQ-017 A load_start in SHIFT, CHECK, ARMED or ERROR SHALL restart the frame: clear the shift register and bit counter, and enter SHIFT.
REQ-018 A load_start in LOCKOUT SHALL be ignored.
REQ-019 In SHIFT, 16 consecutive cycles without key_bit_valid SHALL cause SHIFT -> ERROR (timeout), counted as a failure.
REQ-020 The timeout counter SHALL reset on every accepted bit and on entry to SHIFT.
REQ-021 Latency: if the 8th bit is accepted at edge N, CHECK SHALL be active after edge N and ARMED with keyinput valid after edge N+1.
REQ-022 keyinput SHALL be 7'b0 in every state except ARMED; in ARMED it SHALL equal the registered key bits.
REQ-023 A reload SHALL zero keyinput on the cycle after load_start.
REQ-024 A 2-bit consecutive-failure counter SHALL increment on each parity error or timeout, saturating at 3.
REQ-025 The failure counter SHALL clear on each entry to ARMED.
REQ-026 A failure that brings the count to 3 SHALL enter LOCKOUT instead of ERROR.
REQ-027 LOCKOUT SHALL be exited only by rst.
REQ-028 Outputs SHALL be registered or decoded from registered state only; keyinput SHALL have no combinational path from key_sdi.

Reset
REQ-029 On rst, the state SHALL be IDLE and the shift register, bit counter, timeout counter and failure counter SHALL be 0.
REQ-030 Reset values SHALL be: keyinput = 7'b0; key_armed, key_error, busy and locked_out all = 0.
REQ-031 rst asserted mid-frame or in ARMED SHALL take effect at the next edge and discard the partial or armed key.

Structure
REQ-032 A shared package key_loader_pkg SHALL hold:
- KEY_W = 7
- FRAME_W = 8
- TIMEOUT_CYC = 16
- MAX_FAIL = 3
- the state enumeration type.
REQ-033 The block SHALL be a single module with no sub-modules.
REQ-034 Counter widths SHALL derive from the package constants.

Verification
REQ-035 rst, then load_start, then bits 1,0,1,0,1,1,0 with parity 0 on consecutive cycles -> keyinput = 7'h35 and key_armed = 1 two edges after the last bit.
REQ-036 Same frame with parity 1 -> ERROR, key_error = 1, keyinput = 0.
REQ-037 Three bad frames back to back -> locked_out = 1, then a fourth good frame is ignored and keyinput stays 0 until rst.
REQ-038 load_start, 3 bits, then 16 idle cycles -> ERROR on the 16th idle edge.
REQ-039 load_start plus key_bit_valid in the same cycle, then a good frame -> the first bit is discarded and the result is 7'h35.
REQ-040 ARMED with 7'h35, then load_start -> keyinput = 0 on the next cycle, busy = 1.
REQ-041 ARMED with 7'h35, then rst asserted -> keyinput = 0 and key_armed = 0 after the next edge.
